taillight_pattern_monitor: RTL and testbench
============================================

Name: taillight_pattern_monitor

Overview:
- Observes the 10-bit tail-light LED bus driven by the turn/brake/hazard controller and decodes it back into the operating mode: idle, left, right, left+brake, right+brake, brake or hazard.
- Samples only on a blink-step tick and checks each side's blink sequence for legality.
- Reports the decoded mode, a debounced mode-change pulse and an error count.
- Used on-board as a self-check beside the controller and in benches as the scoreboard front end.

Parameters:
- STABLE_TICKS, 2: consecutive ticks with an identical candidate mode before the mode output commits (1..15).
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  input  1  system clock (divided blink clock domain or ADC_CLK_10 with tick enable).
- reset  input  1  synchronous, active-low.
- tick  input  1  one-cycle sample strobe, one per blink step.
- led  input  10  LED bus; led[9:7] left group, led[6:3] unused, led[2:0] right group.
- mode  output  3  0 IDLE, 1 LEFT, 2 RIGHT, 3 LEFT_BRAKE, 4 RIGHT_BRAKE, 5 BRAKE, 6 HAZARD, 7 UNKNOWN.
- mode_valid  output  1  high once any mode has committed since reset.
- mode_change  output  1  one-cycle pulse when mode changes.
- seq_err  output  1  one-cycle error pulse.
- err_count  output  ERR_W  saturating count of seq_err pulses.

Behaviour:
- Side values:
  - L = led[9:7].
  - R = {led[0], led[1], led[2]}, i.e. R[2]=led[0] and R[0]=led[2] (mirrored wiring).
- Legal side patterns: 000, 001, 011, 111. Step function next(): 000→001→011→111→000.
- Per-side FSM (states UNK, OFF, ON, SEQ) with prev register; updates only on clock edges where tick=1:
  - cur==prev==000 → OFF.
  - cur==prev==111 → ON.
  - cur==next(prev) → SEQ.
  - Any other legal pattern → UNK.
  - prev <= cur on every tick.
- Error conditions, evaluated on tick (any one asserts seq_err in the cycle after the tick edge, once per tick even if several fire):
  - Either side's cur is not a legal pattern (side → UNK).
  - led[6:3] != 0.
  - Side was in SEQ and cur is 001 or 011 but cur != next(prev).
  - A SEQ side dropping to 000 or jumping to 111 is legal (signal off / brake applied) and is not an error.
- Candidate mode, evaluated on the registered side states one cycle after the tick edge:
  - OFF/OFF → IDLE.
  - SEQ/OFF → LEFT.
  - OFF/SEQ → RIGHT.
  - SEQ/ON → LEFT_BRAKE.
  - ON/SEQ → RIGHT_BRAKE.
  - ON/ON → BRAKE.
  - SEQ/SEQ with L==R → HAZARD.
  - Anything else → UNKNOWN.
- Stability counter, advanced once per processed tick:
  - Candidate equal to the previous candidate: count increments, saturating at STABLE_TICKS.
  - Otherwise: count = 1.
  - When count == STABLE_TICKS and candidate != mode: mode <= candidate, mode_change pulses 1 cycle, mode_valid <= 1.
- Latency: tick at edge t; seq_err is high during cycle t+1; mode and mode_change update at edge t+1.
- Back-to-back ticks: each tick is processed independently; the pipeline handles a tick every cycle.
- err_count increments on each seq_err pulse and holds at all-ones.
- Reset (synchronous, reset==0 at a clock edge), takes priority over tick:
  - Outputs: mode=7, mode_valid=0, mode_change=0, seq_err=0, err_count=0.
  - Internal: prev L/R=000, side states UNK, stability count=0, candidate=7, pipeline valid cleared.
  - A tick coincident with reset is discarded; in-flight pipeline results are dropped.
- led is not sampled when tick=0; glitches between ticks are ignored.

Test Plan:
- Idle: reset, then 3 ticks with led=0 → mode 0 committed on the 2nd tick (+1 cycle), mode_change one pulse, mode_valid=1, err_count 0.
- Left: ticks with L=000,001,011,111,000,001 and R=000 → mode=1 after two SEQ/OFF ticks, no seq_err.
- Right brake: L=111 held, R drives led[2:0]=100,110,111,000 (R=001,011,111,000) → mode=4; no error.
- Hazard with brake release: L and R both stepping in phase → mode=6; then both held 111 → mode=5 after STABLE_TICKS.
- Errors: L=010 on one tick → seq_err one pulse, err_count=1. led[4]=1 → err_count=2. L SEQ 001 then 011 then 001 → err_count=3. Force 2^ERR_W+3 errors → err_count saturates at 255.
- Reset mid-operation: assert reset on a tick cycle during LEFT → next cycle mode=7, mode_valid=0, err_count=0, that tick ignored; decoding resumes correctly afterwards.

Source files
------------

// File: rtl/taillight_pattern_monitor.sv
// taillight_pattern_monitor
//   Watches the tail-light LED bus and decodes it back into the operating
//   mode. It also checks that each side's blink sequence is legal.
//
//   State table (per-side classifier):
//     state | meaning
//     UNK   | illegal pattern, or a legal pattern that is not a valid step
//     OFF   | side dark on two consecutive ticks
//     ON    | side fully lit on two consecutive ticks (brake)
//     SEQ   | side advanced one blink step since the previous tick
//
//   Ports:
//     clk         system clock
//     reset       synchronous, active-low
//     tick        one-cycle sample strobe, one per blink step
//     led[9:0]    LED bus: [9:7] left group, [6:3] unused, [2:0] right group
//                 (right group is wired mirrored)
//     mode[2:0]   committed mode: 0 IDLE .. 6 HAZARD, 7 UNKNOWN
//     mode_valid  a mode has committed since reset
//     mode_change one-cycle pulse on each commit
//     seq_err     one-cycle pulse, high in the cycle after an offending tick
//     err_count   saturating count of seq_err pulses
module taillight_pattern_monitor #(
  parameter int unsigned STABLE_TICKS = 2,
  parameter int unsigned ERR_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [9:0]       led,
  output logic [2:0]       mode,
  output logic             mode_valid,
  output logic             mode_change,
  output logic             seq_err,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {S_UNK, S_OFF, S_ON, S_SEQ} side_t;

  localparam logic [2:0] M_IDLE        = 3'd0;
  localparam logic [2:0] M_LEFT        = 3'd1;
  localparam logic [2:0] M_RIGHT       = 3'd2;
  localparam logic [2:0] M_LEFT_BRAKE  = 3'd3;
  localparam logic [2:0] M_RIGHT_BRAKE = 3'd4;
  localparam logic [2:0] M_BRAKE       = 3'd5;
  localparam logic [2:0] M_HAZARD      = 3'd6;
  localparam logic [2:0] M_UNKNOWN     = 3'd7;

  localparam logic [3:0] ST_CNT = 4'(STABLE_TICKS);

  function automatic logic is_legal(input logic [2:0] p);
    return (p == 3'b000) || (p == 3'b001) || (p == 3'b011) || (p == 3'b111);
  endfunction

  // Successor of an illegal pattern is itself illegal, so it never matches
  // a legal cur.
  function automatic logic [2:0] step(input logic [2:0] p);
    case (p)
      3'b000:  return 3'b001;
      3'b001:  return 3'b011;
      3'b011:  return 3'b111;
      3'b111:  return 3'b000;
      default: return 3'b010;
    endcase
  endfunction

  function automatic side_t classify(input logic [2:0] cur, input logic [2:0] prev);
    if (!is_legal(cur))                      return S_UNK;
    else if (cur == prev && cur == 3'b000)   return S_OFF;
    else if (cur == prev && cur == 3'b111)   return S_ON;
    else if (cur == step(prev))              return S_SEQ;
    else                                     return S_UNK;
  endfunction

  // Dropping to 000 or jumping to 111 from SEQ is signal-off / brake, not
  // an error; only a bad partial step is.
  function automatic logic side_err(input side_t st, input logic [2:0] cur,
                                    input logic [2:0] prev);
    return !is_legal(cur) ||
           (st == S_SEQ && (cur == 3'b001 || cur == 3'b011) && cur != step(prev));
  endfunction

  logic [2:0]       cur_l, cur_r;
  logic [2:0]       l_prev_q, l_prev_d, r_prev_q, r_prev_d;
  side_t            l_st_q, l_st_d, r_st_q, r_st_d;
  logic             pend_q, pend_d;
  logic             seq_err_q, seq_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [2:0]       cand_now;
  logic [2:0]       cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic             valid_q, valid_d;
  logic             chg_q, chg_d;

  assign cur_l = led[9:7];
  assign cur_r = {led[0], led[1], led[2]};

  // Candidate from the side states registered on the previous tick edge.
  always_comb begin
    cand_now = M_UNKNOWN;
    case ({l_st_q, r_st_q})
      {S_OFF, S_OFF}: cand_now = M_IDLE;
      {S_SEQ, S_OFF}: cand_now = M_LEFT;
      {S_OFF, S_SEQ}: cand_now = M_RIGHT;
      {S_SEQ, S_ON }: cand_now = M_LEFT_BRAKE;
      {S_ON,  S_SEQ}: cand_now = M_RIGHT_BRAKE;
      {S_ON,  S_ON }: cand_now = M_BRAKE;
      {S_SEQ, S_SEQ}: cand_now = (l_prev_q == r_prev_q) ? M_HAZARD : M_UNKNOWN;
      default:        cand_now = M_UNKNOWN;
    endcase
  end

  always_comb begin
    l_prev_d  = l_prev_q;
    r_prev_d  = r_prev_q;
    l_st_d    = l_st_q;
    r_st_d    = r_st_q;
    pend_d    = tick;
    seq_err_d = 1'b0;
    err_cnt_d = err_cnt_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    valid_d   = valid_q;
    chg_d     = 1'b0;

    if (tick) begin
      l_prev_d  = cur_l;
      r_prev_d  = cur_r;
      l_st_d    = classify(cur_l, l_prev_q);
      r_st_d    = classify(cur_r, r_prev_q);
      seq_err_d = side_err(l_st_q, cur_l, l_prev_q) |
                  side_err(r_st_q, cur_r, r_prev_q) |
                  (led[6:3] != 4'd0);
    end

    if (seq_err_d && err_cnt_q != {ERR_W{1'b1}})
      err_cnt_d = err_cnt_q + 1'b1;

    // Second pipeline stage: debounce the candidate of the previous tick.
    if (pend_q) begin
      cand_d = cand_now;
      if (cand_now == cand_q)
        cnt_d = (cnt_q >= ST_CNT) ? ST_CNT : cnt_q + 4'd1;
      else
        cnt_d = 4'd1;
      if (cnt_d == ST_CNT && cand_now != mode_q) begin
        mode_d  = cand_now;
        chg_d   = 1'b1;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      l_prev_q  <= 3'b000;
      r_prev_q  <= 3'b000;
      l_st_q    <= S_UNK;
      r_st_q    <= S_UNK;
      pend_q    <= 1'b0;
      seq_err_q <= 1'b0;
      err_cnt_q <= '0;
      cand_q    <= M_UNKNOWN;
      cnt_q     <= 4'd0;
      mode_q    <= M_UNKNOWN;
      valid_q   <= 1'b0;
      chg_q     <= 1'b0;
    end else begin
      l_prev_q  <= l_prev_d;
      r_prev_q  <= r_prev_d;
      l_st_q    <= l_st_d;
      r_st_q    <= r_st_d;
      pend_q    <= pend_d;
      seq_err_q <= seq_err_d;
      err_cnt_q <= err_cnt_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      valid_q   <= valid_d;
      chg_q     <= chg_d;
    end
  end

  assign mode        = mode_q;
  assign mode_valid  = valid_q;
  assign mode_change = chg_q;
  assign seq_err     = seq_err_q;
  assign err_count   = err_cnt_q;

endmodule

// File: tb/tb_taillight_pattern_monitor.sv
// tb_taillight_pattern_monitor
//   Directed bench for taillight_pattern_monitor with default parameters.
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge.
module tb_taillight_pattern_monitor;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [9:0] led;
  logic [2:0] mode;
  logic       mode_valid;
  logic       mode_change;
  logic       seq_err;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  taillight_pattern_monitor #(.STABLE_TICKS(2), .ERR_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .led        (led),
    .mode       (mode),
    .mode_valid (mode_valid),
    .mode_change(mode_change),
    .seq_err    (seq_err),
    .err_count  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Right side given in logical order; the bus wiring is mirrored.
  function automatic logic [9:0] mk(input logic [2:0] l, input logic [2:0] r,
                                    input logic [3:0] mid);
    return {l, mid, r[0], r[1], r[2]};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    tick  = 1'b0;
    led   = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // One tick; seq_err checked in the cycle after the tick edge, mode and
  // mode_change one cycle later.
  task automatic tick_chk(input string tag, input logic [2:0] l, input logic [2:0] r,
                          input logic [3:0] mid, input int unsigned e_err,
                          input int unsigned e_mode, input int unsigned e_chg);
    @(negedge clk);
    led  = mk(l, r, mid);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    check({tag, ".seq_err"}, seq_err, e_err);
    @(negedge clk);
    check({tag, ".mode"}, mode, e_mode);
    check({tag, ".mode_change"}, mode_change, e_chg);
    check({tag, ".seq_err_low"}, seq_err, 0);
  endtask

  initial begin
    reset = 1'b0;
    tick  = 1'b0;
    led   = '0;
    repeat (2) @(negedge clk);

    // Idle
    do_reset();
    check("rst.mode", mode, 7);
    check("rst.mode_valid", mode_valid, 0);
    check("rst.mode_change", mode_change, 0);
    check("rst.seq_err", seq_err, 0);
    check("rst.err_count", err_count, 0);
    tick_chk("idle1", 3'b000, 3'b000, 4'h0, 0, 7, 0);
    tick_chk("idle2", 3'b000, 3'b000, 4'h0, 0, 0, 1);
    check("idle.mode_valid", mode_valid, 1);
    tick_chk("idle3", 3'b000, 3'b000, 4'h0, 0, 0, 0);
    // Garbage between ticks must be ignored
    led = 10'h3FF;
    repeat (4) begin
      @(negedge clk);
      check("glitch.seq_err", seq_err, 0);
    end
    check("glitch.mode", mode, 0);
    tick_chk("idle4", 3'b000, 3'b000, 4'h0, 0, 0, 0);
    check("idle.err_count", err_count, 0);

    // Left
    do_reset();
    tick_chk("left1", 3'b000, 3'b000, 4'h0, 0, 7, 0);
    tick_chk("left2", 3'b001, 3'b000, 4'h0, 0, 7, 0);
    tick_chk("left3", 3'b011, 3'b000, 4'h0, 0, 1, 1);
    tick_chk("left4", 3'b111, 3'b000, 4'h0, 0, 1, 0);
    tick_chk("left5", 3'b000, 3'b000, 4'h0, 0, 1, 0);
    tick_chk("left6", 3'b001, 3'b000, 4'h0, 0, 1, 0);
    check("left.err_count", err_count, 0);

    // Right + brake (led[2:0] = 100,110,111,000)
    do_reset();
    tick_chk("rbrk1", 3'b111, 3'b001, 4'h0, 0, 7, 0);
    check("rbrk.led_wiring", led[2:0], 3'b100);
    tick_chk("rbrk2", 3'b111, 3'b011, 4'h0, 0, 7, 0);
    tick_chk("rbrk3", 3'b111, 3'b111, 4'h0, 0, 4, 1);
    tick_chk("rbrk4", 3'b111, 3'b000, 4'h0, 0, 4, 0);
    check("rbrk.err_count", err_count, 0);

    // Hazard, then brake held
    do_reset();
    tick_chk("haz1", 3'b001, 3'b001, 4'h0, 0, 7, 0);
    tick_chk("haz2", 3'b011, 3'b011, 4'h0, 0, 6, 1);
    tick_chk("haz3", 3'b111, 3'b111, 4'h0, 0, 6, 0);
    tick_chk("brk1", 3'b111, 3'b111, 4'h0, 0, 6, 0);
    tick_chk("brk2", 3'b111, 3'b111, 4'h0, 0, 5, 1);

    // Errors
    do_reset();
    tick_chk("err_illegal", 3'b010, 3'b000, 4'h0, 1, 7, 0);
    check("err_illegal.count", err_count, 1);
    tick_chk("err_unused", 3'b000, 3'b000, 4'h2, 1, 7, 0);
    check("err_unused.count", err_count, 2);
    tick_chk("err_seq1", 3'b000, 3'b000, 4'h0, 0, 7, 0);
    tick_chk("err_seq2", 3'b001, 3'b000, 4'h0, 0, 7, 0);
    tick_chk("err_seq3", 3'b011, 3'b000, 4'h0, 0, 1, 1);
    tick_chk("err_seq4", 3'b001, 3'b000, 4'h0, 1, 1, 0);
    check("err_seq.count", err_count, 3);
    // 259 back-to-back error ticks: 3 + 259 saturates at 255
    @(negedge clk);
    led  = mk(3'b000, 3'b000, 4'h2);
    tick = 1'b1;
    repeat (259) @(negedge clk);
    check("flood.seq_err", seq_err, 1);
    tick = 1'b0;
    led  = '0;
    @(negedge clk);
    check("flood.seq_err_low", seq_err, 0);
    check("flood.err_count_sat", err_count, 255);

    // Reset mid-operation, coincident with a tick
    do_reset();
    tick_chk("mid1", 3'b000, 3'b000, 4'h0, 0, 7, 0);
    tick_chk("mid2", 3'b001, 3'b000, 4'h0, 0, 7, 0);
    tick_chk("mid3", 3'b011, 3'b000, 4'h0, 0, 1, 1);
    @(negedge clk);
    reset = 1'b0;
    tick  = 1'b1;
    led   = mk(3'b001, 3'b000, 4'h2);
    @(negedge clk);
    reset = 1'b1;
    tick  = 1'b0;
    led   = '0;
    check("midrst.mode", mode, 7);
    check("midrst.mode_valid", mode_valid, 0);
    check("midrst.mode_change", mode_change, 0);
    check("midrst.seq_err", seq_err, 0);
    check("midrst.err_count", err_count, 0);
    @(negedge clk);
    check("midrst.seq_err2", seq_err, 0);
    check("midrst.mode2", mode, 7);
    tick_chk("resume1", 3'b001, 3'b000, 4'h0, 0, 7, 0);
    tick_chk("resume2", 3'b011, 3'b000, 4'h0, 0, 1, 1);
    check("resume.mode_valid", mode_valid, 1);
    check("resume.err_count", err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
